// File: rtl/vote_ctrl_pkg.sv
// Shared types and helpers for the voting controller: FSM state encoding,
// combine-mode selectors and the per-bit combine function.
package vote_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StRxWait,
    StRxAck,
    StTxReq,
    StTxDone,
    StTest
  } state_e;

  localparam int unsigned MODE_AND = 0;
  localparam int unsigned MODE_OR  = 1;
  localparam int unsigned MODE_XOR = 2;

  // Per-bit merge of a local and a remote vote; unknown modes fall back to AND.
  function automatic logic combine(input int unsigned mode, input logic a, input logic b);
    logic r;
    case (mode)
      MODE_AND: r = a & b;
      MODE_OR:  r = a | b;
      MODE_XOR: r = a ^ b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vote_ctrl_param_if.sv
// Panel and inter-station link signals of the voting controller.
// master = panel/remote side, slave = controller side.
interface vote_ctrl_param_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 8
);
  logic          START;
  logic          TEST;
  logic          KEY;
  logic          G_BUTTON;
  logic          R_BUTTON;
  logic          RTS;
  logic [DW-1:0] V_IN;
  logic          RTR;
  logic          CTS_REG;
  logic          CTR_REG;
  logic [DW-1:0] V_OUT_REG;
  logic          ERR_REG;
  logic [CW-1:0] ROUND_CNT;

  modport master (
    output START, TEST, KEY, G_BUTTON, R_BUTTON, RTS, V_IN, RTR,
    input  CTS_REG, CTR_REG, V_OUT_REG, ERR_REG, ROUND_CNT
  );

  modport slave (
    input  START, TEST, KEY, G_BUTTON, R_BUTTON, RTS, V_IN, RTR,
    output CTS_REG, CTR_REG, V_OUT_REG, ERR_REG, ROUND_CNT
  );
endinterface

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a level button: one-cycle pulse when the input
// goes high relative to its registered previous value.
module btn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= btn;
    end
  end

  assign pulse = btn & ~last_q;

endmodule

// File: rtl/vote_ctrl_param.sv
// Voting controller: collects DW local votes, receives a remote vote word over
// RTS/CTS, combines both and sends the result over CTR/RTR with timeout abort.
module vote_ctrl_param
  import vote_ctrl_pkg::*;
#(
  parameter int unsigned   DW       = 4,
  parameter int unsigned   MODE     = 0,
  parameter int unsigned   TIMEOUT  = 255,
  parameter int unsigned   CW       = 8,
  parameter logic [DW-1:0] TEST_PAT = DW'(4'hA)
) (
  input logic               clk,
  input logic               reset,
  vote_ctrl_param_if.slave  bus
);

  localparam int unsigned     IW        = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned     TW        = $clog2(TIMEOUT);
  localparam logic [IW-1:0]   IdxLast   = IW'(DW - 1);
  localparam logic [TW-1:0]   TimerLast = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] vote_q, vote_d;
  logic [DW-1:0] rx_q, rx_d;
  logic [DW-1:0] vout_q, vout_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] round_q, round_d;
  logic          cts_q, cts_d;
  logic          ctr_q, ctr_d;
  logic          err_q, err_d;
  logic [DW-1:0] combined;
  logic          g_pulse, r_pulse;
  logic          expired, abort;

  btn_edge_det u_g_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.G_BUTTON),
    .pulse (g_pulse)
  );

  btn_edge_det u_r_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.R_BUTTON),
    .pulse (r_pulse)
  );

  always_comb begin
    combined = '0;
    for (int i = 0; i < DW; i++) begin
      combined[i] = combine(MODE, vote_q[i], rx_q[i]);
    end
  end

  assign expired = (timer_q == TimerLast);

  always_comb begin
    state_d = state_q;
    vote_d  = vote_q;
    rx_d    = rx_q;
    vout_d  = vout_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    round_d = round_q;
    cts_d   = cts_q;
    ctr_d   = ctr_q;
    err_d   = err_q;
    abort   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cts_d = 1'b0;
        ctr_d = 1'b0;
        if (bus.START && bus.KEY) begin
          state_d = StCollect;
          vote_d  = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end else if (bus.START && bus.TEST) begin
          state_d = StTest;
          vout_d  = TEST_PAT;
          ctr_d   = 1'b1;
        end
      end
      StCollect: begin
        // Dropping START wins over any button pulse in the same cycle.
        if (!bus.START) begin
          state_d = StIdle;
          vote_d  = '0;
          idx_d   = '0;
        end else if (bus.KEY && (g_pulse ^ r_pulse)) begin
          vote_d[idx_q] = g_pulse;
          if (idx_q == IdxLast) begin
            state_d = StRxWait;
            idx_d   = '0;
            timer_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StRxWait: begin
        timer_d = timer_q + 1'b1;
        if (bus.RTS) begin
          rx_d    = bus.V_IN;
          cts_d   = 1'b1;
          state_d = StRxAck;
          timer_d = '0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRxAck: begin
        timer_d = timer_q + 1'b1;
        if (!bus.RTS) begin
          cts_d   = 1'b0;
          vout_d  = combined;
          ctr_d   = 1'b1;
          state_d = StTxReq;
          timer_d = '0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StTxReq: begin
        timer_d = timer_q + 1'b1;
        if (bus.RTR) begin
          ctr_d   = 1'b0;
          state_d = StTxDone;
          timer_d = '0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StTxDone: begin
        timer_d = timer_q + 1'b1;
        if (!bus.RTR) begin
          round_d = round_q + 1'b1;
          state_d = StIdle;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StTest: begin
        if (bus.TEST) begin
          vout_d = TEST_PAT;
          ctr_d  = 1'b1;
        end else begin
          ctr_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      err_d   = 1'b1;
      cts_d   = 1'b0;
      ctr_d   = 1'b0;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      vote_q  <= '0;
      rx_q    <= '0;
      vout_q  <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      round_q <= '0;
      cts_q   <= 1'b0;
      ctr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vote_q  <= vote_d;
      rx_q    <= rx_d;
      vout_q  <= vout_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      round_q <= round_d;
      cts_q   <= cts_d;
      ctr_q   <= ctr_d;
      err_q   <= err_d;
    end
  end

  assign bus.CTS_REG   = cts_q;
  assign bus.CTR_REG   = ctr_q;
  assign bus.V_OUT_REG = vout_q;
  assign bus.ERR_REG   = err_q;
  assign bus.ROUND_CNT = round_q;

endmodule

// File: tb/tb_vote_ctrl_param.sv
// Bench for vote_ctrl_param: three instances (AND/OR/XOR) share one stimulus;
// expected result words are queued at stimulus time and popped when CTR rises.
module tb_vote_ctrl_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, test = 1'b0, key = 1'b0, g = 1'b0, r = 1'b0;
  logic       rts = 1'b0, rtr = 1'b0;
  logic [3:0] v_in = 4'h0;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_round = 8'd0;
  logic [3:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  vote_ctrl_param_if #(.DW(4), .CW(8)) bus0 ();
  vote_ctrl_param_if #(.DW(4), .CW(8)) bus1 ();
  vote_ctrl_param_if #(.DW(4), .CW(8)) bus2 ();

  assign bus0.START = start;    assign bus1.START = start;    assign bus2.START = start;
  assign bus0.TEST = test;      assign bus1.TEST = test;      assign bus2.TEST = test;
  assign bus0.KEY = key;        assign bus1.KEY = key;        assign bus2.KEY = key;
  assign bus0.G_BUTTON = g;     assign bus1.G_BUTTON = g;     assign bus2.G_BUTTON = g;
  assign bus0.R_BUTTON = r;     assign bus1.R_BUTTON = r;     assign bus2.R_BUTTON = r;
  assign bus0.RTS = rts;        assign bus1.RTS = rts;        assign bus2.RTS = rts;
  assign bus0.V_IN = v_in;      assign bus1.V_IN = v_in;      assign bus2.V_IN = v_in;
  assign bus0.RTR = rtr;        assign bus1.RTR = rtr;        assign bus2.RTR = rtr;

  vote_ctrl_param #(.DW(4), .MODE(0), .TIMEOUT(8), .CW(8), .TEST_PAT(4'hA)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );
  vote_ctrl_param #(.DW(4), .MODE(1), .TIMEOUT(8), .CW(8), .TEST_PAT(4'hA)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );
  vote_ctrl_param #(.DW(4), .MODE(2), .TIMEOUT(8), .CW(8), .TEST_PAT(4'hA)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic pg, input logic pr);
    g = pg;
    r = pr;
    tick();
    g = 1'b0;
    r = 1'b0;
    tick();
  endtask

  task automatic collect(input logic [3:0] v);
    start = 1'b1;
    key   = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) press(v[i], ~v[i]);
    start = 1'b0;
    key   = 1'b0;
  endtask

  // Waits (bounded) for CTR on the AND instance, then pops and compares all three.
  task automatic wait_result(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (bus0.CTR_REG !== 1'b1 && k < 12);
    chk({tag, "_ctr"}, bus0.CTR_REG, 1'b1);
    if (q0.size() > 0) chk({tag, "_and"}, bus0.V_OUT_REG, q0.pop_front());
    if (q1.size() > 0) chk({tag, "_or"},  bus1.V_OUT_REG, q1.pop_front());
    if (q2.size() > 0) chk({tag, "_xor"}, bus2.V_OUT_REG, q2.pop_front());
  endtask

  task automatic handshake(input string tag, input logic [3:0] votes, input logic [3:0] vin);
    q0.push_back(votes & vin);
    q1.push_back(votes | vin);
    q2.push_back(votes ^ vin);
    rts  = 1'b1;
    v_in = vin;
    tick();
    chk({tag, "_cts"}, bus0.CTS_REG, 1'b1);
    rts = 1'b0;
    wait_result(tag);
    chk({tag, "_cts_low"}, bus0.CTS_REG, 1'b0);
    rtr = 1'b1;
    tick();
    chk({tag, "_ctr_low"}, bus0.CTR_REG, 1'b0);
    rtr = 1'b0;
    tick();
    exp_round = exp_round + 8'd1;
    chk({tag, "_round"}, bus0.ROUND_CNT, exp_round);
  endtask

  initial begin
    logic [3:0] rv, rin;

    repeat (2) tick();
    chk("rst_cts", bus0.CTS_REG, 1'b0);
    chk("rst_ctr", bus0.CTR_REG, 1'b0);
    chk("rst_vout", bus0.V_OUT_REG, 4'h0);
    chk("rst_err", bus0.ERR_REG, 1'b0);
    chk("rst_round", bus0.ROUND_CNT, 8'd0);
    reset = 1'b1;
    tick();

    // Votes G,R,G,G -> 4'b1101
    collect(4'b1101);
    handshake("r1", 4'b1101, 4'hF);
    collect(4'b1101);
    handshake("r2", 4'b1101, 4'h3);

    // Simultaneous G+R ignored, held G counts once, KEY=0 press ignored -> 4'b1001
    start = 1'b1;
    key   = 1'b1;
    tick();
    press(1'b1, 1'b1);
    g = 1'b1;
    repeat (3) tick();
    g = 1'b0;
    tick();
    key = 1'b0;
    press(1'b1, 1'b0);
    key = 1'b1;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    start = 1'b0;
    key   = 1'b0;
    handshake("r3", 4'b1001, 4'hF);

    // RTS never arrives: error exactly 8 cycles after RX_WAIT entry
    start = 1'b1;
    key   = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    g = 1'b1;
    tick();
    g     = 1'b0;
    start = 1'b0;
    key   = 1'b0;
    repeat (7) tick();
    chk("to_err_early", bus0.ERR_REG, 1'b0);
    tick();
    chk("to_err", bus0.ERR_REG, 1'b1);
    chk("to_cts", bus0.CTS_REG, 1'b0);
    chk("to_vout_hold", bus0.V_OUT_REG, 4'h9);
    chk("to_round_hold", bus0.ROUND_CNT, exp_round);
    start = 1'b1;
    key   = 1'b1;
    tick();
    chk("to_err_clear", bus0.ERR_REG, 1'b0);
    start = 1'b0;
    key   = 1'b0;
    tick();

    // Test-pattern mode
    q0.push_back(4'hA);
    q1.push_back(4'hA);
    q2.push_back(4'hA);
    start = 1'b1;
    test  = 1'b1;
    wait_result("tm");
    tick();
    chk("tm_ctr_hold", bus0.CTR_REG, 1'b1);
    test = 1'b0;
    tick();
    chk("tm_ctr_drop", bus0.CTR_REG, 1'b0);
    chk("tm_round", bus0.ROUND_CNT, exp_round);
    start = 1'b0;
    tick();

    // Run rounds up to 255, then one more to wrap to 0
    while (exp_round != 8'd255) begin
      rv  = 4'($urandom_range(0, 15));
      rin = 4'($urandom_range(0, 15));
      collect(rv);
      handshake("wrap_run", rv, rin);
    end
    collect(4'b0110);
    handshake("wrap", 4'b0110, 4'h5);
    chk("wrap_zero", bus0.ROUND_CNT, 8'd0);

    // Reset asserted while in TX_REQ
    collect(4'b1111);
    rts  = 1'b1;
    v_in = 4'hF;
    tick();
    rts = 1'b0;
    tick();
    chk("mr_ctr_before", bus0.CTR_REG, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mr_ctr", bus0.CTR_REG, 1'b0);
    chk("mr_cts", bus0.CTS_REG, 1'b0);
    chk("mr_vout", bus0.V_OUT_REG, 4'h0);
    chk("mr_err", bus0.ERR_REG, 1'b0);
    chk("mr_round", bus0.ROUND_CNT, 8'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
